// File: rtl/vsim_flit_packer.sv
// Packs width-bit beats into 144-bit NOCDataH flits ({data[127:0], last, bytes[14:0]}).
// Latency: flit valid the cycle after its completing beat. Backpressure: in RDY from registered state only.
// Optional VSIM_FLIT_PACKER_SKID_EN lets the accumulator fill while a flit is pending.
module vsim_flit_packer #(
    parameter int width = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_enq__ENA,
    input  logic [width-1:0] in_enq_v,
    input  logic             in_enq_last,
    output logic             in_enq__RDY,
    output logic             out_enq__ENA,
    output logic [143:0]     out_enq_v,
    input  logic             out_enq__RDY
);

    localparam int RATIO = 128 / width;
    localparam int CW    = $clog2(RATIO + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);

    logic [127:0]  acc_q, acc_d, acc_w;
    logic [CW-1:0] cnt_q, cnt_d, cnt_w;
    logic          last_q, last_d, last_w;
    logic          full_q, full_d, full_w;
    logic          pend_vld_q, pend_vld_d;
    logic [143:0]  pend_q, pend_d;
    logic [14:0]   len_w;
    logic          beat_fire, drain;

`ifdef VSIM_FLIT_PACKER_SKID_EN
    assign in_enq__RDY = !(pend_vld_q && full_q);
`else
    assign in_enq__RDY = !pend_vld_q;
`endif

    assign beat_fire    = in_enq__ENA && in_enq__RDY;
    assign drain        = pend_vld_q && out_enq__RDY;
    assign out_enq__ENA = pend_vld_q;
    assign out_enq_v    = pend_q;

    always_comb begin
        acc_w = acc_q;
        for (int i = 0; i < RATIO; i++) begin
            if (beat_fire && cnt_q == CW'(i)) begin
                acc_w[i*width +: width] = in_enq_v;
            end
        end
        cnt_w  = cnt_q + CW'(beat_fire);
        last_w = last_q | (beat_fire & in_enq_last);
        // full_q only ever survives a cycle when the pending slot was blocked
        full_w = full_q | (beat_fire & ((cnt_w == CNT_FULL) | in_enq_last));
        len_w  = 15'(cnt_w) * 15'(width / 8);

        acc_d      = acc_w;
        cnt_d      = cnt_w;
        last_d     = last_w;
        full_d     = full_w;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;

        if (drain) begin
            pend_vld_d = 1'b0;
            pend_d     = '0;
        end
        if (full_w && (!pend_vld_q || drain)) begin
            pend_vld_d = 1'b1;
            pend_d     = {acc_w, last_w, len_w};
            acc_d      = '0;
            cnt_d      = '0;
            last_d     = 1'b0;
            full_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            full_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            full_q     <= full_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
        end
    end

endmodule
